bht_predictor: RTL and testbench

//  Branch history table: 2**IDX_W saturating counters, indexed by fetch PC, feeding

---
 rtl/bht_predictor.sv | 152 +++++++++++++++
 tb/tb_bht_predictor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters indexed by fetch PC, trained by resolved branches.
// Optional gshare hashing of the index with a global history register when BHT_GSHARE_EN is defined.
module bht_predictor #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             ready
);

  localparam int               ENTRIES     = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = '1;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] init_ptr;
  logic [IDX_W-1:0] init_ptr_next;

  logic [CNT_W-1:0] table_mem [ENTRIES];
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_new;

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_fire;
  logic             upd_fire;
  logic             unused_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
    end
  end

  // INIT sweeps the table one entry per cycle before any lookup or update is honoured.
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    case (state)
      S_INIT: begin
        init_ptr_next = init_ptr + IDX_W'(1);
        if (init_ptr == IDX_LAST) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        state_next = S_READY;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  assign ready       = (state == S_READY);
  assign lookup_fire = ready && lookup_valid;
  assign upd_fire    = ready && upd_valid;

  assign pc_idx    = lookup_pc[IDX_W+1:2];
  assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  ghr_idx;

  // History is zero-extended or truncated to the index width before hashing.
  if (HIST_W >= IDX_W) begin : g_ghr_trunc
    assign ghr_idx = ghr[IDX_W-1:0];
  end else begin : g_ghr_ext
    assign ghr_idx = {{(IDX_W - HIST_W){1'b0}}, ghr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_fire) begin
      ghr <= HIST_W'({ghr, upd_taken});
    end
  end

  assign lookup_idx = pc_idx ^ ghr_idx;
`else
  logic [HIST_W-1:0] unused_hist;

  assign unused_hist = '0;
  assign lookup_idx  = pc_idx;
`endif

  assign upd_cur = table_mem[upd_idx];

  // Saturating step: never wraps past either end of the counter range.
  always_comb begin
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_MAX) begin
        upd_new = upd_cur + CNT_W'(1);
      end
    end else begin
      if (upd_cur != '0) begin
        upd_new = upd_cur - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) begin
        table_mem[init_ptr] <= CNT_WEAK_NT;
      end else if (upd_fire) begin
        table_mem[upd_idx] <= upd_new;
      end
    end
  end

  // Reads the pre-update counter, so a same-cycle update to this index is seen next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lookup_fire;
      if (lookup_fire) begin
        pred_taken <= table_mem[lookup_idx][CNT_W-1];
        pred_idx   <= lookup_idx;
      end
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios followed by randomized traffic
// compared against an array-of-counters reference model.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        ready;

  int compared;
  int mismatched;

  int cnt_m [64];
  int ghr_m;
  int init_cycles;
  bit ready_m;
  bit pv_m;
  bit pt_m;
  int pidx_m;

  bht_predictor #(
    .PC_W  (32),
    .IDX_W (6),
    .CNT_W (2),
    .HIST_W(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lookup_valid(lookup_valid),
    .lookup_pc   (lookup_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_idx    (pred_idx),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (ready === ready_m) else begin
      mismatched++;
      $error("[TB] FAIL %s ready: observed %b expected %b", tag, ready, ready_m);
    end
    compared++;
    assert (pred_valid === pv_m) else begin
      mismatched++;
      $error("[TB] FAIL %s pred_valid: observed %b expected %b", tag, pred_valid, pv_m);
    end
    compared++;
    assert (pred_taken === pt_m) else begin
      mismatched++;
      $error("[TB] FAIL %s pred_taken: observed %b expected %b", tag, pred_taken, pt_m);
    end
    compared++;
    assert (pred_idx === 6'(pidx_m)) else begin
      mismatched++;
      $error("[TB] FAIL %s pred_idx: observed %0d expected %0d", tag, pred_idx, pidx_m);
    end
  endtask

  // Drives one clock of inputs, advances the reference model for that edge, then checks.
  task automatic applyStimulus(input string tag, input bit r, input bit lv, input logic [31:0] pc,
                               input bit uv, input int ui, input bit ut);
    int idx;
    reset        = r;
    lookup_valid = lv;
    lookup_pc    = pc;
    upd_valid    = uv;
    upd_idx      = ui[5:0];
    upd_taken    = ut;
    @(posedge clk);
    #1;
    if (r) begin
      pv_m        = 1'b0;
      pt_m        = 1'b0;
      pidx_m      = 0;
      ghr_m       = 0;
      init_cycles = 0;
      ready_m     = 1'b0;
    end else if (!ready_m) begin
      pv_m = 1'b0;
      init_cycles++;
      if (init_cycles == 64) begin
        foreach (cnt_m[i]) cnt_m[i] = 1;
        ready_m = 1'b1;
      end
    end else begin
      if (lv) begin
        idx    = (int'(pc >> 2) ^ ghr_m) & 63;
        pv_m   = 1'b1;
        pt_m   = (cnt_m[idx] >= 2);
        pidx_m = idx;
      end else begin
        pv_m = 1'b0;
      end
      if (uv) begin
        if (ut) cnt_m[ui] = (cnt_m[ui] == 3) ? 3 : cnt_m[ui] + 1;
        else    cnt_m[ui] = (cnt_m[ui] == 0) ? 0 : cnt_m[ui] - 1;
`ifdef BHT_GSHARE_EN
        ghr_m = ((ghr_m << 1) | int'(ut)) & 63;
`endif
      end
    end
    reset        = 1'b0;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    int hot;
    logic [31:0] pc;
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    upd_valid    = 1'b0;
    upd_idx      = '0;
    upd_taken    = 1'b0;
    foreach (cnt_m[i]) cnt_m[i] = 0;

    // Reset then 64 cycles of table init; first lookup after ready.
    applyStimulus("t1_reset", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) applyStimulus("t1_init", 0, 1, 32'h40, 1, 16, 1);
    checkValue("t1_ready_after_64", ready, 1);
    applyStimulus("t1_lookup", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t1_pred_valid", pred_valid, 1);
    checkValue("t1_pred_idx", pred_idx, 16);
    checkValue("t1_pred_taken", pred_taken, 0);

`ifndef BHT_GSHARE_EN
    // Train idx16 up to saturation.
    applyStimulus("t2_upd", 0, 0, 0, 1, 16, 1);
    applyStimulus("t2_upd", 0, 0, 0, 1, 16, 1);
    applyStimulus("t2_lookup", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t2_taken_at_3", pred_taken, 1);
    applyStimulus("t2_upd_sat", 0, 0, 0, 1, 16, 1);
    applyStimulus("t2_lookup_sat", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t2_taken_saturated", pred_taken, 1);

    // Train idx16 down through zero.
    for (int i = 0; i < 4; i++) applyStimulus("t3_upd_nt", 0, 0, 0, 1, 16, 0);
    applyStimulus("t3_lookup", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t3_taken_at_0", pred_taken, 0);
    applyStimulus("t3_upd_t", 0, 0, 0, 1, 16, 1);
    applyStimulus("t3_lookup2", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t3_taken_at_1", pred_taken, 0);

    // Same-cycle lookup and update to idx5 reads the old value.
    applyStimulus("t4_same_cycle", 0, 1, 32'h14, 1, 5, 1);
    checkValue("t4_pre_update", pred_taken, 0);
    checkValue("t4_pre_update_idx", pred_idx, 5);
    applyStimulus("t4_next", 0, 1, 32'h14, 0, 0, 0);
    checkValue("t4_post_update", pred_taken, 1);
`else
    // Three updates shift history to 000110, hashing pc 0x40 to index 22.
    applyStimulus("t6_upd", 0, 0, 0, 1, 0, 1);
    applyStimulus("t6_upd", 0, 0, 0, 1, 0, 1);
    applyStimulus("t6_upd", 0, 0, 0, 1, 0, 0);
    applyStimulus("t6_lookup", 0, 1, 32'h40, 0, 0, 0);
    checkValue("t6_hashed_idx", pred_idx, 22);
`endif

    // Reset part way through init restarts the full sweep.
    applyStimulus("t5_reset", 1, 1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus("t5_init_a", 0, 1, $urandom, 1, $urandom_range(0, 63), 1);
    applyStimulus("t5_reset_mid", 1, 1, 32'h40, 0, 0, 0);
    checkValue("t5_ready_in_reset", ready, 0);
    for (int i = 0; i < 64; i++) applyStimulus("t5_init_b", 0, 1, $urandom, 1, $urandom_range(0, 63), 0);

    // Randomized traffic concentrated on a few hot indices.
    for (int n = 0; n < 2000; n++) begin
      hot = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      pc  = ($urandom & 32'hFFFF_FF03) | (32'(hot) << 2);
      hot = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      applyStimulus("rand", ($urandom_range(0, 599) == 0), $urandom_range(0, 1), pc,
                    $urandom_range(0, 1), hot, $urandom_range(0, 1));
    end

    // Reset while ready and trained: every entry must come back weakly not-taken.
    applyStimulus("t5_reset_ready", 1, 1, 32'h40, 0, 0, 0);
    checkValue("t5_pred_valid_dropped", pred_valid, 0);
    for (int i = 0; i < 64; i++) applyStimulus("t5_init_c", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus("t5_sweep", 0, 1, 32'(i) << 2, 0, 0, 0);
      checkValue("t5_entry_weak_nt", pred_taken, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
